etapa_fetch: RTL and testbench

Instruction-fetch stage of the pipelined MIPS core. It holds the program counter and the IF/ID pipeline register. It publishes PC+4 as input 0 of the next-PC `MUX2to1`, which selects between PC+4 and the branch/jump target, and consumes that mux's output as the next PC. It also handles stall, flush, HALT detection and freeze from the debug unit, and keeps a cycle counter for the debug unit.

---
 rtl/etapa_fetch.sv | 91 +++++++++
 tb/tb_etapa_fetch.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/etapa_fetch.sv
// rtl/etapa_fetch.sv - MIPS instruction-fetch stage: PC, IF/ID register, HALT detection, cycle counter
module etapa_fetch #(
  parameter int               ANCHO       = 32,
  parameter logic [ANCHO-1:0] PC_RESET    = 32'h0000_0000,
  parameter logic [ANCHO-1:0] OPCODE_HALT = 32'hFFFF_FFFF,
  parameter logic [ANCHO-1:0] NOP         = 32'h0000_0000
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_habilitar,
  input  logic [ANCHO-1:0] i_pc_siguiente,
  input  logic [ANCHO-1:0] i_instruccion,
  input  logic             i_stall,
  input  logic             i_flush,
  output logic [ANCHO-1:0] o_pc,
  output logic [ANCHO-1:0] o_pc_mas4,
  output logic [ANCHO-1:0] o_if_id_pc_mas4,
  output logic [ANCHO-1:0] o_if_id_instruccion,
  output logic             o_if_id_valido,
  output logic             o_halt,
  output logic [31:0]      o_ciclos
);

  typedef enum logic {EJECUTANDO = 1'b0, DETENIDO = 1'b1} estado_t;

  estado_t          estado;
  logic [ANCHO-1:0] pc;
  logic [ANCHO-1:0] if_id_pc_mas4;
  logic [ANCHO-1:0] if_id_instruccion;
  logic             if_id_valido;
  logic             halt;
  logic [31:0]      ciclos;
  logic [ANCHO-1:0] pc_mas4;

  // PC+4 feeds the next-PC mux combinationally; wraps naturally at 2^ANCHO
  assign pc_mas4 = pc + ANCHO'(4);

  // PC, IF/ID, state and counter update with flush > stall > HALT > fetch priority
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      estado            <= EJECUTANDO;
      pc                <= PC_RESET;
      if_id_pc_mas4     <= '0;
      if_id_instruccion <= NOP;
      if_id_valido      <= 1'b0;
      halt              <= 1'b0;
      ciclos            <= '0;
    end else if (i_habilitar) begin
      // stalled and flushed cycles still count while running
      if (estado == EJECUTANDO) begin
        ciclos <= ciclos + 32'd1;
      end
      if (i_flush) begin
        // squash whatever was fetched; a squashed HALT never halts
        pc                <= i_pc_siguiente;
        if_id_pc_mas4     <= '0;
        if_id_instruccion <= NOP;
        if_id_valido      <= 1'b0;
        estado            <= EJECUTANDO;
        halt              <= 1'b0;
      end else if (i_stall) begin
        // load-use hazard: everything holds
      end else if (estado == EJECUTANDO) begin
        if_id_pc_mas4     <= pc_mas4;
        if_id_instruccion <= i_instruccion;
        if_id_valido      <= 1'b1;
        if (i_instruccion == OPCODE_HALT) begin
          // HALT goes down the pipeline, PC parks on it
          estado <= DETENIDO;
          halt   <= 1'b1;
        end else begin
          pc <= i_pc_siguiente;
        end
      end else begin
        // halted: drain the pipeline with bubbles
        if_id_pc_mas4     <= '0;
        if_id_instruccion <= NOP;
        if_id_valido      <= 1'b0;
      end
    end
  end

  assign o_pc                = pc;
  assign o_pc_mas4           = pc_mas4;
  assign o_if_id_pc_mas4     = if_id_pc_mas4;
  assign o_if_id_instruccion = if_id_instruccion;
  assign o_if_id_valido      = if_id_valido;
  assign o_halt              = halt;
  assign o_ciclos            = ciclos;

endmodule

// File: tb/tb_etapa_fetch.sv
// tb/tb_etapa_fetch.sv - randomized self-checking bench for etapa_fetch against a behavioural model
module tb_etapa_fetch;

  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hab;
  logic [31:0] pc_sig;
  logic [31:0] instr;
  logic        stall;
  logic        flush;
  logic [31:0] pc;
  logic [31:0] pc_mas4;
  logic [31:0] if_pc4;
  logic [31:0] if_ins;
  logic        if_val;
  logic        halt;
  logic [31:0] ciclos;

  logic [31:0] imem [256];

  int n_vec = 0;
  int n_err = 0;

  // behavioural model state
  logic [31:0] m_pc, m_ifpc, m_ifins, m_cyc;
  logic        m_val, m_halt;

  always #5 clk = ~clk;

  assign instr = imem[pc[9:2]];

  etapa_fetch dut (
    .i_clock             (clk),
    .i_reset             (rst_n),
    .i_habilitar         (hab),
    .i_pc_siguiente      (pc_sig),
    .i_instruccion       (instr),
    .i_stall             (stall),
    .i_flush             (flush),
    .o_pc                (pc),
    .o_pc_mas4           (pc_mas4),
    .o_if_id_pc_mas4     (if_pc4),
    .o_if_id_instruccion (if_ins),
    .o_if_id_valido      (if_val),
    .o_halt              (halt),
    .o_ciclos            (ciclos)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ifpc = 32'h0; m_ifins = 32'h0; m_val = 1'b0; m_halt = 1'b0; m_cyc = 32'h0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},     pc,      m_pc);
    chk({tag, ".pc4"},    pc_mas4, m_pc + 32'd4);
    chk({tag, ".ifpc"},   if_pc4,  m_ifpc);
    chk({tag, ".ifins"},  if_ins,  m_ifins);
    chk({tag, ".val"},    {31'b0, if_val}, {31'b0, m_val});
    chk({tag, ".halt"},   {31'b0, halt},   {31'b0, m_halt});
    chk({tag, ".ciclos"}, ciclos,  m_cyc);
  endtask

  // one clock: drive at negedge, model the edge, compare at next negedge
  task automatic step(input logic h, input logic s, input logic f, input logic [31:0] target, input string tag);
    logic [31:0] ins;
    logic [31:0] nxt;
    ins    = imem[m_pc[9:2]];
    nxt    = f ? target : m_pc + 32'd4;
    hab    = h;
    stall  = s;
    flush  = f;
    pc_sig = nxt;
    if (h) begin
      if (!m_halt) m_cyc = m_cyc + 32'd1;
      if (f) begin
        m_pc = nxt; m_ifpc = 0; m_ifins = 0; m_val = 0; m_halt = 0;
      end else if (s) begin
      end else if (!m_halt && ins == HALT_W) begin
        m_ifpc = m_pc + 32'd4; m_ifins = HALT_W; m_val = 1; m_halt = 1;
      end else if (!m_halt) begin
        m_ifpc = m_pc + 32'd4; m_ifins = ins; m_val = 1; m_pc = nxt;
      end else begin
        m_ifpc = 0; m_ifins = 0; m_val = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = $urandom & 32'h7FFF_FFFF;
    rst_n = 1'b0; hab = 1'b0; stall = 1'b0; flush = 1'b0; pc_sig = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // normal fetch, then stall at PC 8, then flush to 0x40
    step(1, 0, 0, 0, "fetch1");
    chk("fetch1.pc4_exact", if_pc4, 32'd4);
    chk("fetch1.ins_exact", if_ins, imem[0]);
    step(1, 0, 0, 0, "fetch2");
    chk("fetch2.pc_exact", pc, 32'd8);
    step(1, 1, 0, 0, "stall1");
    step(1, 1, 0, 0, "stall2");
    chk("stall.pc_exact", pc, 32'd8);
    chk("stall.ciclos4", ciclos, 32'd4);
    step(1, 0, 1, 32'h40, "flush40");
    chk("flush40.pc_exact", pc, 32'h40);
    chk("flush40.val0", {31'b0, if_val}, 32'd0);
    step(1, 0, 0, 0, "after40");
    chk("after40.ins_exact", if_ins, imem[16]);

    // HALT at 0x10, drain, resume by flush while halted
    imem[4] = HALT_W;
    step(1, 0, 1, 32'h10, "to10");
    step(1, 0, 0, 0, "halt");
    chk("halt.pc_exact", pc, 32'h10);
    chk("halt.ins_exact", if_ins, HALT_W);
    chk("halt.halt1", {31'b0, halt}, 32'd1);
    step(1, 0, 0, 0, "drain1");
    step(1, 0, 0, 0, "drain2");
    chk("drain.ciclos_frozen", ciclos, 32'd8);
    step(1, 0, 1, 32'h80, "resume80");
    chk("resume80.halt0", {31'b0, halt}, 32'd0);

    // squashed HALT: flush while fetching HALT
    step(1, 0, 1, 32'h10, "to10b");
    step(1, 0, 1, 32'h80, "squash");
    chk("squash.pc_exact", pc, 32'h80);
    imem[4] = $urandom & 32'h7FFF_FFFF;

    // freeze
    for (int i = 0; i < 5; i++) step(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, "freeze");

    // PC wrap
    step(1, 0, 1, 32'hFFFF_FFFC, "pcwrap");
    chk("pcwrap.pc4_zero", pc_mas4, 32'h0);

    // counter wrap
    force dut.ciclos = 32'hFFFF_FFFF;
    #1;
    release dut.ciclos;
    m_cyc = 32'hFFFF_FFFF;
    step(1, 0, 0, 0, "cycwrap");
    chk("cycwrap.zero", ciclos, 32'h0);

    // async reset mid-run while halted at 0x24
    imem[9] = HALT_W;
    step(1, 0, 1, 32'h24, "to24");
    step(1, 0, 0, 0, "halt24");
    chk("halt24.halt1", {31'b0, halt}, 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("asyncrst");
    @(negedge clk);
    rst_n = 1'b1;
    imem[9] = $urandom & 32'h7FFF_FFFF;

    // randomized run with a few HALT words planted
    for (int i = 0; i < 6; i++) imem[$urandom_range(0, 255)] = HALT_W;
    for (int i = 0; i < 2000; i++) begin
      logic h, s, f;
      h = ($urandom_range(0, 9) != 0);
      s = ($urandom_range(0, 6) == 0);
      f = ($urandom_range(0, 9) == 0);
      step(h, s, f, $urandom & 32'h0000_03FC, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
